// File: rtl/johnson_phase_monitor.sv
// Samples a Johnson counter code, decodes it to a phase index and tracks sequencing:
// illegal-code and wrong-successor pulses, lock after a run of good steps, and a saturating wrap count.
module johnson_phase_monitor #(
    parameter int WIDTH      = 4,
    parameter int PH_W       = 3,
    parameter int LOCK_CNT   = 3,
    parameter int CNT_W      = 8,
    parameter int ALLOW_HOLD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] jc_in,
    output logic [PH_W-1:0]  phase,
    output logic             phase_valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic             wrap,
    output logic [CNT_W-1:0] wrap_cnt
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    localparam logic [PH_W-1:0] PH_MAX = PH_W'(2 * WIDTH - 1);
    localparam logic [3:0]      GOOD_TARGET = 4'(LOCK_CNT);

    state_t           state_reg;
    logic [3:0]       good_reg;
    logic [PH_W-1:0]  pop_sum [WIDTH+1];
    logic [PH_W-1:0]  dec_phase;
    logic [PH_W-1:0]  succ_phase;
    logic [WIDTH-1:0] pow_chk;
    logic             code_legal;
    logic             is_succ;
    logic             is_hold;

    assign pop_sum[0] = '0;
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pop
        assign pop_sum[gi+1] = pop_sum[gi] + {{(PH_W-1){1'b0}}, jc_in[gi]};
    end

    // 2*WIDTH is 0 modulo 2**PH_W, so the msb=1 branch reduces to a plain negation.
    assign dec_phase = jc_in[WIDTH-1] ? (PH_W'(2 * WIDTH) - pop_sum[WIDTH]) : pop_sum[WIDTH];

    // A Johnson state (or its complement when msb=1) is a run of low ones: adding 1 gives a power of two.
    assign pow_chk    = jc_in[WIDTH-1] ? (~jc_in + WIDTH'(1)) : (jc_in + WIDTH'(1));
    assign code_legal = (pow_chk != '0) && ((pow_chk & (pow_chk - WIDTH'(1))) == '0);

    assign succ_phase = (phase == PH_MAX) ? '0 : phase + PH_W'(1);
    assign is_succ    = (dec_phase == succ_phase);
    assign is_hold    = (ALLOW_HOLD != 0) && (dec_phase == phase);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            good_reg    <= '0;
            phase       <= '0;
            phase_valid <= 1'b0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;
            locked      <= 1'b0;
            wrap        <= 1'b0;
            wrap_cnt    <= '0;
        end else begin
            illegal <= 1'b0;
            seq_err <= 1'b0;
            wrap    <= 1'b0;
            if (en) begin
                if (!code_legal) begin
                    // Any illegal code falls back to IDLE; phase keeps the last legal value.
                    illegal     <= 1'b1;
                    phase_valid <= 1'b0;
                    locked      <= 1'b0;
                    good_reg    <= '0;
                    state_reg   <= IDLE;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            state_reg   <= ACQUIRE;
                            phase       <= dec_phase;
                            phase_valid <= 1'b1;
                            good_reg    <= '0;
                        end
                        ACQUIRE: begin
                            if (is_succ) begin
                                phase    <= dec_phase;
                                good_reg <= good_reg + 4'd1;
                                if (good_reg + 4'd1 == GOOD_TARGET) begin
                                    state_reg <= LOCKED;
                                    locked    <= 1'b1;
                                end
                            end else if (!is_hold) begin
                                seq_err  <= 1'b1;
                                good_reg <= '0;
                                phase    <= dec_phase;
                            end
                        end
                        LOCKED: begin
                            if (is_succ) begin
                                phase <= dec_phase;
                                if (phase == PH_MAX) begin
                                    wrap <= 1'b1;
                                    if (wrap_cnt != '1) begin
                                        wrap_cnt <= wrap_cnt + CNT_W'(1);
                                    end
                                end
                            end else if (!is_hold) begin
                                seq_err   <= 1'b1;
                                good_reg  <= '0;
                                phase     <= dec_phase;
                                locked    <= 1'b0;
                                state_reg <= ACQUIRE;
                            end
                        end
                        default: begin
                            state_reg <= IDLE;
                            locked    <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
